// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle shift controller. It drives a 16-bit single-step `shifter` once
// per clock so the datapath can perform shifts of 0..(2^AMT_W-1) positions
// without a barrel shifter. One request is accepted through a start/busy/done
// handshake. The operand is held in an internal working register (result).
//
// Optional feature: define SHIFT_SEQ_CARRY_EN to add the `cout` output. It
// holds the last bit shifted out of the operand.
//
// Ports (shift_sequencer):
//   clk     in   1      rising-edge clock
//   reset   in   1      synchronous, active-high reset
//   start   in   1      request strobe, sampled on the rising edge
//   din     in   16     operand to shift
//   op      in   2      00 pass, 01 shl1, 10 lsr1, 11 asr1
//   amt     in   AMT_W  number of single-bit steps
//   result  out  16     working/result register
//   busy    out  1      high while shift steps are in progress
//   done    out  1      one-cycle completion pulse; result valid while high
//   cout    out  1      last bit shifted out (SHIFT_SEQ_CARRY_EN only)
//
// Ports (shifter):
//   din     in   16     operand
//   op      in   2      shift select, same encoding as above
//   dout    out  16     operand shifted by one position (or passed through)
// ---------------------------------------------------------------------------

// Single-step shifter. It is purely combinational, so the sequencer owns all
// of the state.
module shifter (
   input  logic [15:0] din,
   input  logic [1:0]  op,
   output logic [15:0] dout
);

   always_comb begin
      unique case (op)
         2'b01:   dout = {din[14:0], 1'b0};        // shift left, LSB <- 0
         2'b10:   dout = {1'b0, din[15:1]};        // logical right, MSB <- 0
         2'b11:   dout = {din[15], din[15:1]};     // arithmetic right, MSB kept
         default: dout = din;                      // pass-through
      endcase
   end

endmodule

module shift_sequencer #(
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [15:0]      din,
   input  logic [1:0]       op,
   input  logic [AMT_W-1:0] amt,
   output logic [15:0]      result,
   output logic             busy,
   output logic             done
`ifdef SHIFT_SEQ_CARRY_EN
   ,
   output logic             cout
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      result_q, result_d;
   logic [AMT_W-1:0] count_q, count_d;
   logic [1:0]       op_q, op_d;
   logic [15:0]      shift_out;

   // The shifter always looks at the working register and the latched op, so
   // each SHIFT cycle simply reloads result with the shifter output.
   shifter u_shifter (
      .din  (result_q),
      .op   (op_q),
      .dout (shift_out)
   );

`ifdef SHIFT_SEQ_CARRY_EN
   logic carry_q, carry_d;
   logic step_carry;

   // Bit leaving the operand on this step: bit15 for left shifts, bit0 for
   // either right shift. Pass-through discards nothing, so the carry stays 0.
   always_comb begin
      unique case (op_q)
         2'b01:        step_carry = result_q[15];
         2'b10, 2'b11: step_carry = result_q[0];
         default:      step_carry = 1'b0;
      endcase
   end
`endif

   // Next-state and next-value logic.
   // NOTE: every variable assigned here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      count_d  = count_q;
      op_d     = op_q;
`ifdef SHIFT_SEQ_CARRY_EN
      carry_d  = carry_q;
`endif

      unique case (state_q)
         // IDLE and DONE share the acceptance path. This gives back-to-back
         // operation when start is held across the done pulse.
         IDLE, DONE: begin
            if (start) begin
               result_d = din;
               op_d     = op;
               count_d  = amt;
`ifdef SHIFT_SEQ_CARRY_EN
               carry_d  = 1'b0;
`endif
               // amt == 0 goes straight to DONE. This is the only way a zero
               // count is reached, so the counter never underflows in SHIFT.
               state_d  = (amt != '0) ? SHIFT : DONE;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end

         // start is ignored here: the request in flight runs to completion.
         SHIFT: begin
            result_d = shift_out;
            count_d  = count_q - AMT_W'(1);
`ifdef SHIFT_SEQ_CARRY_EN
            carry_d  = step_carry;
`endif
            if (count_q == AMT_W'(1)) begin
               state_d = DONE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register. Reset is synchronous and overrides start, so a request
   // in flight is aborted with no done pulse.
   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         result_q <= 16'h0000;
         count_q  <= '0;
         op_q     <= 2'b00;
`ifdef SHIFT_SEQ_CARRY_EN
         carry_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         count_q  <= count_d;
         op_q     <= op_d;
`ifdef SHIFT_SEQ_CARRY_EN
         carry_q  <= carry_d;
`endif
      end
   end

   // Handshake outputs are decoded from the registered state only. There is
   // no combinational path from start to busy or done.
   assign busy   = (state_q == SHIFT);
   assign done   = (state_q == DONE);
   assign result = result_q;
`ifdef SHIFT_SEQ_CARRY_EN
   assign cout   = carry_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
//
// Directed bench for shift_sequencer. Expected values are hand-computed
// constants. Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_shift_sequencer;

   localparam int AMT_W = 4;

   logic             clk;
   logic             reset;
   logic             start;
   logic [15:0]      din;
   logic [1:0]       op;
   logic [AMT_W-1:0] amt;
   logic [15:0]      result;
   logic             busy;
   logic             done;
`ifdef SHIFT_SEQ_CARRY_EN
   logic             cout;
`endif

   int n_checks = 0;
   int n_fails  = 0;

   shift_sequencer #(.AMT_W(AMT_W)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .din    (din),
      .op     (op),
      .amt    (amt),
      .result (result),
      .busy   (busy),
      .done   (done)
`ifdef SHIFT_SEQ_CARRY_EN
      ,
      .cout   (cout)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request before edge E0. Return at E0+1 with start released.
   task automatic issue(input logic [15:0] d, input logic [1:0] o,
                        input logic [AMT_W-1:0] a);
      @(negedge clk);
      start = 1'b1;
      din   = d;
      op    = o;
      amt   = a;
      @(posedge clk);
      #1;
      start = 1'b0;
      // Scramble the operand inputs. Only the accepting edge may sample them.
      din   = ~d;
      op    = ~o;
      amt   = ~a;
   endtask

   // Full transaction with exact latency: busy for amt cycles, then done for
   // one cycle, then the result is held in IDLE.
   task automatic run_op(input string tag, input logic [15:0] d,
                         input logic [1:0] o, input logic [AMT_W-1:0] a,
                         input logic [15:0] exp_res, input logic exp_cout);
      int busy_cycles;
      int done_early;
      busy_cycles = 0;
      done_early  = 0;
      issue(d, o, a);
      for (int i = 0; i < int'(a); i++) begin
         if (busy === 1'b1) busy_cycles++;
         if (done !== 1'b0) done_early++;
         tick();
      end
      check($sformatf("%s_busy_cycles", tag), busy_cycles, int'(a));
      check($sformatf("%s_done_early", tag), done_early, 0);
      check($sformatf("%s_done", tag), {31'd0, done}, 1);
      check($sformatf("%s_busy_at_done", tag), {31'd0, busy}, 0);
      check($sformatf("%s_result", tag), {16'd0, result}, {16'd0, exp_res});
`ifdef SHIFT_SEQ_CARRY_EN
      check($sformatf("%s_cout", tag), {31'd0, cout}, {31'd0, exp_cout});
`else
      if (exp_cout === 1'bx) $display("note: unexpected carry request");
`endif
      tick();
      check($sformatf("%s_done_pulse_len", tag), {31'd0, done}, 0);
      check($sformatf("%s_result_hold", tag), {16'd0, result}, {16'd0, exp_res});
   endtask

   initial begin
      int done_seen;
      reset = 1'b1;
      start = 1'b0;
      din   = 16'h0000;
      op    = 2'b00;
      amt   = '0;
      tick();
      tick();
      check("reset_result", {16'd0, result}, 32'h0);
      check("reset_busy", {31'd0, busy}, 0);
      check("reset_done", {31'd0, done}, 0);
`ifdef SHIFT_SEQ_CARRY_EN
      check("reset_cout", {31'd0, cout}, 0);
`endif
      reset = 1'b0;
      tick();

      // Basic ops on 16'hF0CF.
      run_op("shl4", 16'hF0CF, 2'b01, 4'd4, 16'h0CF0, 1'b1);
      run_op("lsr3", 16'hF0CF, 2'b10, 4'd3, 16'h1E19, 1'b1);
      run_op("asr3", 16'hF0CF, 2'b11, 4'd3, 16'hFE19, 1'b1);
      run_op("amt0", 16'hF0CF, 2'b01, 4'd0, 16'hF0CF, 1'b0);
      run_op("pass5", 16'hF0CF, 2'b00, 4'd5, 16'hF0CF, 1'b0);

      // start while busy is ignored; start during DONE is accepted.
      issue(16'h0001, 2'b01, 4'd4);           // accepted at E0
      tick();                                  // E1+1: second busy cycle
      start = 1'b1;
      din   = 16'hFFFF;
      op    = 2'b10;
      amt   = 4'd2;
      tick();                                  // E2+1
      start = 1'b0;
      check("ign_busy", {31'd0, busy}, 1);
      tick();                                  // E3+1
      tick();                                  // E4+1: DONE
      check("ign_done", {31'd0, done}, 1);
      check("ign_result", {16'd0, result}, 32'h0010);
      start = 1'b1;                            // request during DONE
      din   = 16'h0003;
      op    = 2'b01;
      amt   = 4'd1;
      tick();                                  // E5+1
      start = 1'b0;
      check("b2b_busy", {31'd0, busy}, 1);
      check("b2b_no_done", {31'd0, done}, 0);
      tick();                                  // E6+1
      check("b2b_done", {31'd0, done}, 1);
      check("b2b_result", {16'd0, result}, 32'h0006);
      tick();

      // Reset mid-operation aborts with no done pulse.
      issue(16'h8000, 2'b11, 4'd8);
      tick();
      tick();
      tick();                                  // three shift steps applied
      check("abort_pre_busy", {31'd0, busy}, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_result", {16'd0, result}, 32'h0);
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_done", {31'd0, done}, 0);
`ifdef SHIFT_SEQ_CARRY_EN
      check("abort_cout", {31'd0, cout}, 0);
`endif
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done !== 1'b0 || busy !== 1'b0) done_seen++;
      end
      check("abort_no_done", done_seen, 0);

      // Maximum amount.
      run_op("asr15", 16'h8000, 2'b11, 4'd15, 16'hFFFF, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller that drives the existing 16-bit single-step `shifter` to perform shifts of 0..(2^AMT_W-1) bit positions.
- Accepts one request through a start/busy/done handshake and holds the operand in an internal register.
- Applies the shifter's 1-bit operation once per clock until the amount is exhausted.
- Sits beside the datapath's B-operand path, so the datapath can issue multi-bit shift instructions without a barrel shifter.

Parameters:
- AMT_W, 4, width of the shift-amount input; maximum shift = 2^AMT_W-1 (15 by default). Data width is fixed at 16 to match `shifter`.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled on clk rising edge
- din  input  16  operand to shift
- op  input  2  00 pass-through, 01 shift left by 1 (LSB filled with 0), 10 logical shift right by 1 (MSB filled with 0), 11 arithmetic shift right by 1 (MSB = old bit15)
- amt  input  AMT_W  number of single-bit steps
- result  output  16  working/result register
- busy  output  1  high while shift steps are in progress
- done  output  1  one-cycle completion pulse; result valid while high
- cout  output  1  present only with SHIFT_SEQ_CARRY_EN (see Optional Feature)

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-high and has priority over all other inputs.
- Reset values: state=IDLE, result=16'h0000, busy=0, done=0, step counter=0, latched op=00, cout=0.
- Internal structure:
  - One `shifter` instance; its input is result, its shift select is the latched op.
  - Step counter is AMT_W bits wide.
- States: IDLE, SHIFT, DONE. busy = (state==SHIFT); done = (state==DONE). Both are registered-state decodes with no combinational path from start.
- IDLE:
  - If start=1: result<=din, op latched, counter<=amt.
  - Next state = SHIFT if amt!=0, else DONE.
  - If start=0: hold.
- SHIFT:
  - Each clock: result<=shifter output, counter<=counter-1.
  - When counter==1 at the edge, the next state is DONE. Exactly amt steps are applied.
- DONE:
  - Lasts exactly one cycle.
  - If start=1: accept a new request with the same actions as IDLE (back-to-back operation).
  - Otherwise go to IDLE.
- Latency: with start sampled at edge E0, done is high between edges E(amt) and E(amt+1). For amt=0, done is high between E0 and E1 and busy never asserts.
- Result holding:
  - result holds its final value in IDLE until the next accepted start.
  - During SHIFT, result shows intermediate values; consumers use it only when done=1 or in IDLE.
- start while busy: ignored. No queuing and no effect on the operation in flight.
- Input sampling: din, op and amt are sampled only on the accepting edge. Later changes to them have no effect.
- op=00 with amt>0: runs amt cycles and result stays equal to din. Timing is identical to the other ops.
- Reset mid-operation: aborts immediately to the reset values. No done pulse is generated for the aborted request.
- Counter: never underflows. A zero count is only reachable via the amt=0 path straight to DONE.

Optional Feature:
- Macro: SHIFT_SEQ_CARRY_EN.
- Defined: output cout exists and holds the last bit shifted out of the operand.
  - Left: old bit15. Right (10/11): old bit0.
  - Updated on every SHIFT step.
  - Cleared to 0 on reset and on each accepted start.
  - Remains 0 for amt=0 or op=00.
  - Held in IDLE.
- Undefined: cout port and its register are absent. All other behaviour is identical.

Test Plan:
- Reset, then din=16'hF0CF, op=01, amt=4, start for 1 cycle -> busy high for 4 cycles, then done for 1 cycle with result=16'h0CF0 (cout=1 if SHIFT_SEQ_CARRY_EN).
- din=16'hF0CF, op=10, amt=3 -> done 4 cycles after the start edge, result=16'h1E19 (cout=1). Repeat with op=11 -> result=16'hFE19.
- din=16'hF0CF, op=01, amt=0 -> busy never high, done in the cycle after the start edge, result=16'hF0CF (cout=0). op=00, amt=5 -> result=16'hF0CF after 5 busy cycles.
- Start op=01, amt=4, din=16'h0001. Assert start with din=16'hFFFF, op=10 during cycle 2 of busy -> ignored, final result=16'h0010. Then start during the DONE cycle -> accepted, busy next cycle.
- Start op=11, amt=8, din=16'h8000. Assert reset after 3 busy cycles -> next cycle state IDLE, result=0, busy=0, and no done pulse follows.
- After the reset case, din=16'h8000, op=11, amt=15 -> result=16'hFFFF with done exactly 16 cycles after the start edge (maximum-amount boundary).
